// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared mode/select constants and 7-segment glyph table
// Purpose: constants shared by the add/sub/accumulate datapath and the display scanner.
package addsub_pkg;

    localparam logic [1:0] MODE_ADD     = 2'd0;
    localparam logic [1:0] MODE_SUB     = 2'd1;
    localparam logic [1:0] MODE_ACC_ADD = 2'd2;
    localparam logic [1:0] MODE_ACC_SUB = 2'd3;

    localparam logic [1:0] SEL_RES   = 2'd0;
    localparam logic [1:0] SEL_A     = 2'd1;
    localparam logic [1:0] SEL_B     = 2'd2;
    localparam logic [1:0] SEL_FLAGS = 2'd3;

    // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][7:0] GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage

// File: rtl/addsub_acc_disp_if.sv
// rtl/addsub_acc_disp_if.sv - switch/button/flag/display bundle for addsub_acc_disp
// Purpose: groups operands, controls, results and the display bus.
// master: board/bench side (drives a, b, mode, go, clr, disp_sel).
// slave : datapath side (drives result, carry, ovf, zero, done, DISP).
interface addsub_acc_disp_if #(
    parameter int W = 8
);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic         go;
    logic         clr;
    logic [1:0]   disp_sel;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;
    logic         done;
    logic [11:0]  DISP;

    modport master (
        output a, b, mode, go, clr, disp_sel,
        input  result, carry, ovf, zero, done, DISP
    );

    modport slave (
        input  a, b, mode, go, clr, disp_sel,
        output result, carry, ovf, zero, done, DISP
    );
endinterface

// File: rtl/addsub_acc_disp_seg7_scan.sv
// rtl/addsub_acc_disp_seg7_scan.sv - 4-digit multiplexed 7-segment hex scanner
// Purpose: cycles through the four nibbles of value, each digit lit for SCAN_DIV cycles.
// Ports: CLK, RST_N (async active-low), value (16-bit), DISP (12-bit:
//        [11:8] active-low digit enables, bit 8 rightmost; [7:0] active-low segments).
module seg7_scan
    import addsub_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] value,
    output logic [11:0] DISP
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   disp_q, disp_d;
    logic [3:0]    nib;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        nib    = value[{idx_q, 2'b00} +: 4];
        // Enable and segments come from the same idx_q, so they move together.
        disp_d = {~(4'b0001 << idx_q), GLYPH[nib]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            disp_q <= 12'hFFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
        end
    end

    assign DISP = disp_q;
endmodule

// File: rtl/addsub_acc_disp.sv
// rtl/addsub_acc_disp.sv - registered add/sub/accumulate unit with flags and hex display
// Purpose: button-triggered W-bit add/sub/accumulate with carry/ovf/zero flags and a
//          scanned 4-digit display of result, a, b or flags.
// Ports: CLK, RST_N (async active-low), bus (addsub_acc_disp_if.slave):
//        a, b, mode, go, clr, disp_sel in; result, carry, ovf, zero, done, DISP out.
module addsub_acc_disp
    import addsub_pkg::*;
#(
    parameter int W           = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    addsub_acc_disp_if.slave    bus
);
    // Button synchronisers: index 0 = go, index 1 = clr.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;

    assign btn_raw = {bus.clr, bus.go};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   edge_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync_q <= '0;
                edge_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
                edge_q <= sync_q[SYNC_STAGES-1];
            end
        end

        // Rising edge only, so a held button yields a single operation.
        assign btn_pulse[gi] = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    logic go_p, clr_p;
    assign go_p  = btn_pulse[0];
    assign clr_p = btn_pulse[1];

    // Datapath
    logic [W-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic         done_q, done_d;

    logic         is_acc, is_sub;
    logic [W-1:0] op_a, op_b;
    logic [W:0]   sum;
    logic         sum_ovf;

    always_comb begin
        is_acc  = (bus.mode == MODE_ACC_ADD) || (bus.mode == MODE_ACC_SUB);
        is_sub  = (bus.mode == MODE_SUB) || (bus.mode == MODE_ACC_SUB);
        op_a    = is_acc ? result_q : bus.a;
        // Subtraction is a + ~b + 1, so carry out doubles as "no borrow".
        op_b    = is_sub ? ~bus.b : bus.b;
        sum     = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(is_sub);
        sum_ovf = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
    end

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (clr_p) begin
            // clr takes priority; a coincident go is discarded.
            result_d = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            zero_d   = 1'b1;
        end else if (go_p) begin
            result_d = sum[W-1:0];
            carry_d  = sum[W];
            ovf_d    = sum_ovf;
            zero_d   = (sum[W-1:0] == '0);
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;

    // Display value: widen to 32 bits first so any W in 4..32 truncates/extends cleanly.
    logic [31:0] res_ext, a_ext, b_ext;
    logic [15:0] disp_val;

    assign res_ext = 32'(result_q);
    assign a_ext   = 32'(bus.a);
    assign b_ext   = 32'(bus.b);

    always_comb begin
        disp_val = res_ext[15:0];
        case (bus.disp_sel)
            SEL_RES:   disp_val = res_ext[15:0];
            SEL_A:     disp_val = a_ext[15:0];
            SEL_B:     disp_val = b_ext[15:0];
            SEL_FLAGS: disp_val = {13'b0, carry_q, ovf_q, zero_q};
            default:   disp_val = res_ext[15:0];
        endcase
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .CLK   (CLK),
        .RST_N (RST_N),
        .value (disp_val),
        .DISP  (bus.DISP)
    );
endmodule

// File: tb/tb_addsub_acc_disp.sv
// tb/tb_addsub_acc_disp.sv - directed self-checking bench for addsub_acc_disp
module tb_addsub_acc_disp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    addsub_acc_disp_if #(.W(8)) bus ();

    addsub_acc_disp #(
        .W           (8),
        .SCAN_DIV    (4),
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // Stimulus only: hold go/clr for 5 cycles, release for 4, count done pulses.
    task automatic press(input logic g, input logic c, output int dcnt);
        dcnt = 0;
        @(negedge clk);
        bus.go  = g;
        bus.clr = c;
        repeat (5) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
        bus.go  = 1'b0;
        bus.clr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcnt++;
        end
    endtask

    task automatic test_reset;
        bus.a = 8'h00; bus.b = 8'h00; bus.mode = 2'd0;
        bus.go = 1'b0; bus.clr = 1'b0; bus.disp_sel = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", bus.zero); end
        checks++; if ({bus.carry, bus.ovf, bus.done} !== 3'b000) begin failures++; $display("FAIL reset_cod got=%b exp=000", {bus.carry, bus.ovf, bus.done}); end
        checks++; if (bus.DISP !== 12'hFFF) begin failures++; $display("FAIL reset_disp got=%h exp=FFF", bus.DISP); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.DISP[11:8] !== 4'hE) begin failures++; $display("FAIL reset_release_en got=%h exp=E", bus.DISP[11:8]); end
    endtask

    task automatic test_add_latency;
        bus.mode = 2'd0; bus.a = 8'hF0; bus.b = 8'h20;
        @(negedge clk);
        bus.go = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== (c == 3)) begin failures++; $display("FAIL add_done_c%0d got=%b exp=%b", c, bus.done, (c == 3)); end
            if (c == 2) begin
                checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL add_early got=%h exp=00", bus.result); end
            end
            if (c == 3) begin
                checks++; if (bus.result !== 8'h10) begin failures++; $display("FAIL add_result got=%h exp=10", bus.result); end
                checks++; if ({bus.carry, bus.ovf, bus.zero} !== 3'b100) begin failures++; $display("FAIL add_flags got=%b exp=100", {bus.carry, bus.ovf, bus.zero}); end
            end
        end
        bus.go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sub;
        int d;
        bus.mode = 2'd1; bus.a = 8'h80; bus.b = 8'h01;
        press(1'b1, 1'b0, d);
        checks++; if (d !== 1) begin failures++; $display("FAIL sub1_done got=%0d exp=1", d); end
        checks++; if (bus.result !== 8'h7F) begin failures++; $display("FAIL sub1_result got=%h exp=7F", bus.result); end
        checks++; if ({bus.carry, bus.ovf, bus.zero} !== 3'b110) begin failures++; $display("FAIL sub1_flags got=%b exp=110", {bus.carry, bus.ovf, bus.zero}); end
        bus.a = 8'h05; bus.b = 8'h05;
        press(1'b1, 1'b0, d);
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL sub2_result got=%h exp=00", bus.result); end
        checks++; if ({bus.carry, bus.ovf, bus.zero} !== 3'b101) begin failures++; $display("FAIL sub2_flags got=%b exp=101", {bus.carry, bus.ovf, bus.zero}); end
    endtask

    task automatic test_acc;
        int d;
        logic [7:0] exp_r [4];
        logic [2:0] exp_f [4];
        exp_r[0] = 8'h40; exp_f[0] = 3'b000;
        exp_r[1] = 8'h80; exp_f[1] = 3'b010;
        exp_r[2] = 8'hC0; exp_f[2] = 3'b000;
        exp_r[3] = 8'h00; exp_f[3] = 3'b101;
        press(1'b0, 1'b1, d);
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL acc_clr got=%h exp=00", bus.result); end
        bus.mode = 2'd2; bus.b = 8'h40; bus.a = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            press(1'b1, 1'b0, d);
            checks++; if (bus.result !== exp_r[i]) begin failures++; $display("FAIL acc%0d_result got=%h exp=%h", i, bus.result, exp_r[i]); end
            checks++; if ({bus.carry, bus.ovf, bus.zero} !== exp_f[i]) begin failures++; $display("FAIL acc%0d_flags got=%b exp=%b", i, {bus.carry, bus.ovf, bus.zero}, exp_f[i]); end
        end
        // Accumulating subtract through zero: borrow -> carry=0.
        bus.mode = 2'd3; bus.b = 8'h01;
        press(1'b1, 1'b0, d);
        checks++; if (bus.result !== 8'hFF) begin failures++; $display("FAIL accsub_result got=%h exp=FF", bus.result); end
        checks++; if ({bus.carry, bus.ovf, bus.zero} !== 3'b000) begin failures++; $display("FAIL accsub_flags got=%b exp=000", {bus.carry, bus.ovf, bus.zero}); end
    endtask

    task automatic test_clr;
        int d;
        bus.mode = 2'd2; bus.b = 8'h11;
        press(1'b1, 1'b0, d);
        checks++; if ({bus.carry, bus.result} !== 9'h110) begin failures++; $display("FAIL clr_setup got=%h exp=110", {bus.carry, bus.result}); end
        press(1'b1, 1'b1, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL clrgo_done got=%0d exp=0", d); end
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL clrgo_result got=%h exp=00", bus.result); end
        checks++; if ({bus.carry, bus.ovf, bus.zero} !== 3'b001) begin failures++; $display("FAIL clrgo_flags got=%b exp=001", {bus.carry, bus.ovf, bus.zero}); end
        bus.b = 8'h05;
        press(1'b1, 1'b0, d);
        checks++; if (bus.result !== 8'h05) begin failures++; $display("FAIL clr_acc got=%h exp=05", bus.result); end
        press(1'b0, 1'b1, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL clr_done got=%0d exp=0", d); end
        checks++; if ({bus.result, bus.zero} !== 9'h001) begin failures++; $display("FAIL clr_only got=%h exp=001", {bus.result, bus.zero}); end
    endtask

    task automatic test_reset_midop;
        int d;
        bus.mode = 2'd0; bus.a = 8'h12; bus.b = 8'h34;
        press(1'b1, 1'b0, d);
        checks++; if (bus.result !== 8'h46) begin failures++; $display("FAIL midop_setup got=%h exp=46", bus.result); end
        bus.a = 8'h01; bus.b = 8'h01;
        @(negedge clk);
        bus.go = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL midop_async_result got=%h exp=00", bus.result); end
        checks++; if ({bus.carry, bus.ovf, bus.zero, bus.done} !== 4'b0010) begin failures++; $display("FAIL midop_async_flags got=%b exp=0010", {bus.carry, bus.ovf, bus.zero, bus.done}); end
        checks++; if (bus.DISP !== 12'hFFF) begin failures++; $display("FAIL midop_async_disp got=%h exp=FFF", bus.DISP); end
        bus.go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done === 1'b1) d++;
        end
        checks++; if (d !== 0) begin failures++; $display("FAIL midop_done got=%0d exp=0", d); end
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL midop_result got=%h exp=00", bus.result); end
    endtask

    task automatic test_scan;
        logic [11:0] exp_d [4];
        exp_d[0] = 12'hEC6;
        exp_d[1] = 12'hDB0;
        exp_d[2] = 12'hBC0;
        exp_d[3] = 12'h7C0;
        bus.disp_sel = 2'd1; bus.a = 8'h3C;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (bus.DISP !== exp_d[i/4]) begin failures++; $display("FAIL scan_c%0d got=%h exp=%h", i, bus.DISP, exp_d[i/4]); end
        end
        @(negedge clk);
        checks++; if (bus.DISP !== exp_d[0]) begin failures++; $display("FAIL scan_wrap got=%h exp=%h", bus.DISP, exp_d[0]); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub();
        test_acc();
        test_clr();
        test_reset_midop();
        test_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
